// File: rtl/bp_fe_queue_ckpt_pkg.sv
// FE->BE queue packet layout and the widths derived from the processor config.
package bp_fe_queue_ckpt_pkg;

    localparam int vaddr_width_p               = 39;
    localparam int instr_width_p               = 32;
    localparam int branch_metadata_fwd_width_p = 36;

    typedef enum logic [0:0] {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_queue_type_e;

    typedef struct packed {
        bp_fe_queue_type_e                       msg_type;
        logic [vaddr_width_p-1:0]                pc;
        logic [instr_width_p-1:0]                instr;
        logic [branch_metadata_fwd_width_p-1:0]  branch_metadata_fwd;
    } bp_fe_queue_s;

    localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bp_fe_queue_ckpt_mem.sv
// 1-write / 1-read register file: synchronous write, asynchronous read.
module bp_fe_queue_ckpt_mem #(
    parameter int width_p = 8,
    parameter int els_p   = 8,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i)
            mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_ckpt.sv
// Checkpointing FE->BE queue: entries stay resident until deq so issue can roll
// back to the oldest uncommitted packet and replay it.
module bp_fe_queue_ckpt
    import bp_fe_queue_ckpt_pkg::*;
#(
    parameter int els_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_yumi_i,
    input  logic                         fe_queue_roll_i,
    input  logic                         fe_queue_deq_i,
    input  logic                         fe_queue_clr_i,
    output logic                         empty_o
);

    localparam int lg_els_lp    = $clog2(els_p);
    localparam int ptr_width_lp = lg_els_lp + 1;

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
    logic full, enq;

    // Wrap bits differ but indices match: writer is a full lap ahead of commit.
    assign full = (wptr_r[ptr_width_lp-1] != cptr_r[ptr_width_lp-1])
               && (wptr_r[lg_els_lp-1:0] == cptr_r[lg_els_lp-1:0]);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = (rptr_r != wptr_r);
    assign empty_o          = (wptr_r == cptr_r);
    assign enq              = fe_queue_v_i & ~full & ~fe_queue_clr_i;

    // Commit moves first so a same-cycle roll lands on the post-deq pointer,
    // and clear collapses the writer onto wherever the reader ends up.
    always_comb begin
        cptr_n = cptr_r + ptr_width_lp'(fe_queue_deq_i);
        rptr_n = fe_queue_roll_i ? cptr_n : rptr_r + ptr_width_lp'(fe_queue_yumi_i);
        wptr_n = fe_queue_clr_i  ? rptr_n : wptr_r + ptr_width_lp'(enq);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    bp_fe_queue_ckpt_mem #(
        .width_p(fe_queue_width_lp),
        .els_p  (els_p)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (enq),
        .w_addr_i(wptr_r[lg_els_lp-1:0]),
        .w_data_i(fe_queue_i),
        .r_addr_i(rptr_r[lg_els_lp-1:0]),
        .r_data_o(fe_queue_o)
    );

`ifndef SYNTHESIS
    a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_queue_yumi_i |-> fe_queue_v_o);
    a_deq_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_queue_deq_i |-> (cptr_r != rptr_r));
    a_enq_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (fe_queue_v_i & ~fe_queue_clr_i) |-> fe_queue_ready_o);
`endif

endmodule
